// File: rtl/ahbl_cache_bridge.sv
// AHB-Lite slave that turns each bus transfer into one single-cycle request to a cache
// controller. It inserts wait states while the cache is busy and answers illegal transfers
// with a two-cycle ERROR response.
module ahbl_cache_bridge #(
  parameter int unsigned ADDR_WIDTH = 23
) (
  input  logic        clk,
  input  logic        rst_x,
  input  logic [31:0] ahbls_haddr,
  input  logic [1:0]  ahbls_htrans,
  input  logic        ahbls_hwrite,
  input  logic [2:0]  ahbls_hsize,
  input  logic        ahbls_hready,
  input  logic [31:0] ahbls_hwdata,
  output logic        ahbls_hreadyout,
  output logic        ahbls_hresp,
  output logic [31:0] ahbls_hrdata,
  output logic        o_rd_en,
  output logic        o_wr_en,
  output logic [31:0] o_addr,
  output logic [31:0] o_data,
  output logic [3:0]  o_mask,
  input  logic [31:0] i_data,
  input  logic        i_busy,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StReq  = 3'd1,
    StWait = 3'd2,
    StDone = 3'd3,
    StErr1 = 3'd4,
    StErr2 = 3'd5
  } state_e;

  // Bytes inside the cache window; anything with a bit set outside this mask is out of range.
  localparam logic [31:0] AddrMask =
      (ADDR_WIDTH >= 32) ? 32'hFFFF_FFFF : ((32'd1 << ADDR_WIDTH) - 32'd1);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] hrdata_q, hrdata_d;

  logic [3:0]  req_mask;
  logic        size_ok;
  logic        addr_ok;
  logic        accept;
  logic        legal;

  // htrans[0] only separates SEQ from NONSEQ, which this slave treats identically.
  logic unused_htrans0;
  assign unused_htrans0 = ahbls_htrans[0];

  // Byte-lane mask and alignment check for the transfer in its address phase.
  always_comb begin
    req_mask = 4'b0000;
    size_ok  = 1'b0;
    case (ahbls_hsize)
      3'd0: begin
        req_mask = 4'b0001 << ahbls_haddr[1:0];
        size_ok  = 1'b1;
      end
      3'd1: begin
        req_mask = 4'b0011 << {ahbls_haddr[1], 1'b0};
        size_ok  = ~ahbls_haddr[0];
      end
      3'd2: begin
        req_mask = 4'b1111;
        size_ok  = (ahbls_haddr[1:0] == 2'b00);
      end
      default: begin
        req_mask = 4'b0000;
        size_ok  = 1'b0;
      end
    endcase
  end

  assign addr_ok = ((ahbls_haddr & ~AddrMask) == 32'd0);
  assign legal   = size_ok & addr_ok;
  assign accept  = ahbls_hready & ahbls_htrans[1];

  // Next-state, latched request fields and bus/cache handshake outputs.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    write_d         = write_q;
    mask_d          = mask_q;
    hrdata_d        = hrdata_q;
    ahbls_hreadyout = 1'b1;
    ahbls_hresp     = 1'b0;
    o_rd_en         = 1'b0;
    o_wr_en         = 1'b0;
    unique case (state_q)
      StIdle, StDone, StErr2: begin
        ahbls_hresp = (state_q == StErr2);
        state_d     = StIdle;
        if (accept) begin
          addr_d  = ahbls_haddr & AddrMask;
          write_d = ahbls_hwrite;
          mask_d  = req_mask;
          state_d = legal ? StReq : StErr1;
        end
      end
      StReq: begin
        ahbls_hreadyout = 1'b0;
        if (!i_busy) begin
          o_rd_en = ~write_q;
          o_wr_en = write_q;
          state_d = StWait;
        end
      end
      StWait: begin
        ahbls_hreadyout = 1'b0;
        if (!i_busy) begin
          if (!write_q) begin
            hrdata_d = i_data;
          end
          state_d = StDone;
        end
      end
      StErr1: begin
        ahbls_hreadyout = 1'b0;
        ahbls_hresp     = 1'b1;
        state_d         = StErr2;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and latched request registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_q  <= StIdle;
      addr_q   <= 32'd0;
      write_q  <= 1'b0;
      mask_q   <= 4'b0000;
      hrdata_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      mask_q   <= mask_d;
      hrdata_q <= hrdata_d;
    end
  end

  assign ahbls_hrdata = hrdata_q;
  assign o_addr       = addr_q;
  assign o_mask       = mask_q;
  assign o_data       = ahbls_hwdata;
  assign o_state      = state_q;

endmodule

// File: doc/ahbl_cache_bridge.md
AHBL_CACHE_BRIDGE -- requirements
Module: ahbl_cache_bridge

Interface
REQ-001 Parameter: ADDR_WIDTH, default 23, byte-address width of the cache/SDRAM window; addresses at or above 2^ADDR_WIDTH get an error response.
REQ-002 clk  in  1  single system clock; all state updates on its rising edge.
REQ-003 rst_x  in  1  reset, asynchronous, active-low.
REQ-004 ahbls_haddr  in  32  AHB-Lite address.
REQ-005 ahbls_htrans  in  2  AHB-Lite transfer type; bit 1 set means NONSEQ or SEQ.
REQ-006 ahbls_hwrite  in  1  1 = write.
REQ-007 ahbls_hsize  in  3  0 = byte, 1 = halfword, 2 = word.
REQ-008 ahbls_hready  in  1  bus-wide ready; address phase is sampled only when this is 1.
REQ-009 ahbls_hwdata  in  32  write data, valid during the data phase.
REQ-010 ahbls_hreadyout  out  1  data-phase complete.
REQ-011 ahbls_hresp  out  1  1 = ERROR.
REQ-012 ahbls_hrdata  out  32  read data, registered.
REQ-013 o_rd_en, o_wr_en  out  1 each  single-cycle request pulses to the cache controller.
REQ-014 o_addr  out  32  registered request address; bits [31:ADDR_WIDTH] are driven as 0.
REQ-015 o_data  out  32  write data to the cache controller; equals ahbls_hwdata.
REQ-016 o_mask  out  4  registered byte-lane enables; bit n covers data bits [8n+7:8n].
REQ-017 i_data  in  32  cache read data.
REQ-018 i_busy  in  1  cache controller busy.
REQ-019 o_state  out  3  current FSM state, for debug.

Function
REQ-020 States and encodings: IDLE=0, REQ=1, WAIT=2, DONE=3, ERR1=4, ERR2=5.
REQ-021 Acceptance: in IDLE, DONE or ERR2, a transfer is accepted when ahbls_hready=1 and ahbls_htrans[1]=1.
  - On acceptance, haddr, hwrite and the computed mask are latched.
  - If the transfer is legal, the next state is REQ; if illegal, the next state is ERR1.
  - With no acceptance, the next state is IDLE.
REQ-022 Mask rule:
  - hsize 0 gives 4'b0001 shifted left by haddr[1:0].
  - hsize 1 gives 4'b0011 shifted left by {haddr[1],1'b0}.
  - hsize 2 gives 4'b1111.
REQ-023 Illegal transfers, each answered with an ERROR response:
  - hsize greater than 2;
  - hsize 1 with haddr[0]=1;
  - hsize 2 with haddr[1:0] not equal to 0;
  - haddr at or above 2^ADDR_WIDTH.
REQ-024 REQ state:
  - ahbls_hreadyout=0.
  - When i_busy=0, exactly one of o_rd_en or o_wr_en (chosen by the latched hwrite) is 1 combinationally, and the next state is WAIT.
  - When i_busy=1, no pulse is issued and the FSM stays in REQ.
REQ-025 WAIT state:
  - ahbls_hreadyout=0; no request pulses.
  - When i_busy=0, a read latches i_data into ahbls_hrdata and the next state is DONE.
  - A write leaves ahbls_hrdata unchanged.
REQ-026 DONE state: ahbls_hreadyout=1 and ahbls_hresp=0.
REQ-027 Resulting latency: a cache read hit or a write with zero cache busy cycles completes with exactly 2 wait states (hreadyout low in REQ and WAIT, high in DONE). Each i_busy=1 cycle seen in REQ or WAIT adds one wait state.
REQ-028 Error response:
  - ERR1: hreadyout=0, hresp=1; the next state is always ERR2.
  - ERR2: hreadyout=1, hresp=1.
  - No cache request is issued for an errored transfer.
REQ-029 IDLE: hreadyout=1, hresp=0; htrans IDLE/BUSY transfers get a zero-wait OKAY.
REQ-030 o_rd_en and o_wr_en are never both 1, and are never 1 outside REQ.
REQ-031 Back-to-back transfers: a transfer accepted in DONE goes straight to REQ with no IDLE cycle in between.

Reset
REQ-032 While rst_x=0, outputs are forced asynchronously to these values:
  - state IDLE;
  - hreadyout=1, hresp=0;
  - hrdata=0, o_addr=0, o_mask=0;
  - o_rd_en=0, o_wr_en=0.
REQ-033 Reset asserted mid-transfer (REQ or WAIT) abandons the transfer. After release, the first edge evaluates acceptance from IDLE, and no stale pulse is issued.

Verification
REQ-034 Word read hit at 0x100, i_busy held 0, i_data=0xDEADBEEF:
  - o_rd_en pulses once with o_addr=0x100 and o_mask=4'b1111;
  - hreadyout is 0,0,1 over the data phase and hrdata=0xDEADBEEF.
REQ-035 Byte write at 0x103 with hwdata=0xAB000000, i_busy=1 for 4 cycles after the pulse:
  - o_wr_en pulses once with o_mask=4'b1000 and o_data=0xAB000000;
  - the data phase shows 6 wait states, then OKAY.
REQ-036 i_busy=1 on entry to REQ for 3 cycles: no pulse is issued during those 3 cycles; a single pulse is issued in the cycle i_busy falls.
REQ-037 Illegal transfers, each checked separately: halfword at 0x101, word at 0x102, hsize=3, haddr=0x00800000 with ADDR_WIDTH=23:
  - each gets the two-cycle ERROR response (0/1 then 1/1 on hreadyout/hresp);
  - o_rd_en and o_wr_en stay 0.
REQ-038 Back-to-back: a read accepted in the DONE cycle of a write produces REQ on the next cycle; the two pulses are separated by the write's full completion.
REQ-039 rst_x pulled low while in WAIT:
  - outputs hold their reset values immediately, with no clock edge needed;
  - after release with htrans=IDLE, the FSM stays in IDLE and no pulse appears.
